instruction_cache: RTL and testbench

- Responder end of the fetch-to-icache interface: accepts one instruction-word lookup per cycle from the instruction fetch stage.
- Returns data and hit status exactly one cycle later.
- Direct-mapped, read-only instruction cache. On a miss it fills the whole line from memory over a word-serial request/ack bus.
- The fetcher re-issues missed addresses; the cache never queues requests.

---
 rtl/icache_pkg.sv | 31 +++
 rtl/icache_data_ram.sv | 22 ++
 rtl/instruction_cache.sv | 134 +++++++++++++
 tb/tb_instruction_cache.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared types, default geometry and address-field helpers for the instruction cache.
package icache_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    FINISH = 2'd2
  } state_e;

  localparam int NUM_LINES_DEF      = 64;
  localparam int WORDS_PER_LINE_DEF = 16;
  localparam int WORD_BITS          = $clog2(WORDS_PER_LINE_DEF);
  localparam int INDEX_BITS         = $clog2(NUM_LINES_DEF);
  localparam int TAG_BITS           = 32 - 2 - WORD_BITS - INDEX_BITS;

  // Field widths are arguments so instances with non-default geometry share these helpers.
  function automatic logic [31:0] addr_word(input logic [31:0] addr, input int word_bits);
    return (addr >> 2) & ((32'd1 << word_bits) - 32'd1);
  endfunction

  function automatic logic [31:0] addr_index(input logic [31:0] addr, input int word_bits,
                                             input int index_bits);
    return (addr >> (2 + word_bits)) & ((32'd1 << index_bits) - 32'd1);
  endfunction

  function automatic logic [31:0] addr_tag(input logic [31:0] addr, input int word_bits,
                                           input int index_bits);
    return addr >> (2 + word_bits + index_bits);
  endfunction

endpackage

// File: rtl/icache_data_ram.sv
// Instruction data store: one registered read port for lookups, one write port for line fills.
module icache_data_ram #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rd_en_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [31:0]   rd_data_o,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [31:0]   wr_data_i
);

  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
    if (rd_en_i) rd_data_o <= mem_q[rd_addr_i];
  end

endmodule

// File: rtl/instruction_cache.sv
// Direct-mapped read-only instruction cache with one-cycle lookup latency and
// word-serial line fill over a request/ack memory bus.
module instruction_cache
  import icache_pkg::*;
#(
  parameter int NUM_LINES      = NUM_LINES_DEF,
  parameter int WORDS_PER_LINE = WORDS_PER_LINE_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] iaddress_i,
  input  logic        iaccess_i,
  output logic [31:0] idata_o,
  output logic        icache_hit_o,
  output logic        mem_request_o,
  output logic [31:0] mem_address_o,
  input  logic [31:0] mem_data_i,
  input  logic        mem_ack_i
);

  localparam int WORD_W  = $clog2(WORDS_PER_LINE);
  localparam int INDEX_W = $clog2(NUM_LINES);
  localparam int TAG_W   = 32 - 2 - WORD_W - INDEX_W;
  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(WORDS_PER_LINE - 1);

  logic [WORD_W-1:0]  look_word;
  logic [INDEX_W-1:0] look_index;
  logic [TAG_W-1:0]   look_tag;
  logic               unused_offset;

  assign look_word     = WORD_W'(addr_word(iaddress_i, WORD_W));
  assign look_index    = INDEX_W'(addr_index(iaddress_i, WORD_W, INDEX_W));
  assign look_tag      = TAG_W'(addr_tag(iaddress_i, WORD_W, INDEX_W));
  assign unused_offset = ^iaddress_i[1:0];

  state_e             state_q, state_d;
  logic               lookup_q;
  logic [TAG_W-1:0]   look_tag_q;
  logic [INDEX_W-1:0] look_index_q;
  logic [TAG_W-1:0]   tag_rd_q;
  logic               valid_rd_q;
  logic               valid_q [NUM_LINES];
  logic [TAG_W-1:0]   tag_mem_q [NUM_LINES];
  logic [TAG_W-1:0]   miss_tag_q;
  logic [INDEX_W-1:0] miss_index_q;
  logic [WORD_W-1:0]  cnt_q;
  logic [31:0]        ram_rd_data;

  logic tag_match, hit, miss_start, fill_ack, last_ack;

  assign tag_match  = valid_rd_q && (tag_rd_q == look_tag_q);
  assign hit        = lookup_q && tag_match && (state_q == IDLE);
  assign miss_start = lookup_q && !tag_match && (state_q == IDLE);
  assign fill_ack   = (state_q == FILL) && mem_ack_i;
  assign last_ack   = fill_ack && (cnt_q == LAST_WORD);

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (miss_start) state_d = FILL;
      FILL:    if (last_ack)   state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    icache_hit_o  = hit;
    idata_o       = hit ? ram_rd_data : 32'd0;
    mem_request_o = (state_q == FILL);
    mem_address_o = (state_q == FILL) ? {miss_tag_q, miss_index_q, cnt_q, 2'b00} : 32'd0;
  end

  // Only lookups issued while idle count; those issued mid-fill are dropped for the fetcher to retry.
  always_ff @(posedge clk) begin
    if (reset) lookup_q <= 1'b0;
    else       lookup_q <= iaccess_i && (state_q == IDLE);
  end

  always_ff @(posedge clk) begin
    if (iaccess_i) begin
      look_tag_q   <= look_tag;
      look_index_q <= look_index;
      tag_rd_q     <= tag_mem_q[look_index];
      valid_rd_q   <= valid_q[look_index];
    end
    if (!reset && state_q == FINISH) tag_mem_q[miss_index_q] <= miss_tag_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      miss_tag_q   <= '0;
      miss_index_q <= '0;
      cnt_q        <= '0;
    end else if (miss_start) begin
      miss_tag_q   <= look_tag_q;
      miss_index_q <= look_index_q;
      cnt_q        <= '0;
    end else if (fill_ack) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Valid drops when a fill starts so a partially written line is never reported as a hit.
  for (genvar gi = 0; gi < NUM_LINES; gi++) begin : g_valid
    always_ff @(posedge clk) begin
      if (reset)
        valid_q[gi] <= 1'b0;
      else if (miss_start && look_index_q == INDEX_W'(gi))
        valid_q[gi] <= 1'b0;
      else if (state_q == FINISH && miss_index_q == INDEX_W'(gi))
        valid_q[gi] <= 1'b1;
    end
  end

  icache_data_ram #(
    .DEPTH(NUM_LINES * WORDS_PER_LINE),
    .AW   (INDEX_W + WORD_W)
  ) u_data_ram (
    .clk      (clk),
    .rd_en_i  (iaccess_i),
    .rd_addr_i({look_index, look_word}),
    .rd_data_o(ram_rd_data),
    .wr_en_i  (fill_ack),
    .wr_addr_i({miss_index_q, cnt_q}),
    .wr_data_i(mem_data_i)
  );

endmodule

// File: tb/tb_instruction_cache.sv
// Randomized and directed bench for instruction_cache against a line-level cache model.
module tb_instruction_cache;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] iaddress_i = '0;
  logic        iaccess_i = 1'b0;
  logic [31:0] idata_o;
  logic        icache_hit_o;
  logic        mem_request_o;
  logic [31:0] mem_address_o;
  logic [31:0] mem_data_i = '0;
  logic        mem_ack_i = 1'b0;

  always #5 clk = ~clk;

  instruction_cache dut (
    .clk          (clk),
    .reset        (reset),
    .iaddress_i   (iaddress_i),
    .iaccess_i    (iaccess_i),
    .idata_o      (idata_o),
    .icache_hit_o (icache_hit_o),
    .mem_request_o(mem_request_o),
    .mem_address_o(mem_address_o),
    .mem_data_i   (mem_data_i),
    .mem_ack_i    (mem_ack_i)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Backing memory image: line 0x1000 holds 0xA0000000 + word number.
  function automatic logic [31:0] memfn(input logic [31:0] a);
    return 32'hA000_0000 + (((a & ~32'd3) - 32'h1000) >> 2);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (line-level) ----------------
  bit          m_valid [64];
  logic [31:0] m_tag   [64];
  int          phase = 0;          // 0 idle, 1 filling, 2 finishing
  int          prev_phase;
  logic [31:0] f_tag;
  int          f_idx, f_cnt, li;
  bit          look = 0, hit_now;
  logic [31:0] look_a = '0;
  bit          exp_hit, exp_req;
  logic [31:0] exp_data, exp_addr;
  bit          model_ready = 0;

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
      phase = 0;
      look  = 0;
    end else begin
      li = int'((look_a >> 6) & 32'h3F);
      hit_now = look && phase == 0 && m_valid[li] && m_tag[li] == (look_a >> 12);
      prev_phase = phase;
      case (phase)
        0: if (look && !hit_now) begin
             f_tag = look_a >> 12; f_idx = li; f_cnt = 0;
             m_valid[li] = 1'b0; phase = 1;
           end
        1: if (mem_ack_i) begin
             f_cnt++;
             if (f_cnt == 16) phase = 2;
           end
        default: begin
             m_tag[f_idx] = f_tag; m_valid[f_idx] = 1'b1; phase = 0;
           end
      endcase
      look   = iaccess_i && prev_phase == 0;
      look_a = iaddress_i;
    end
    li       = int'((look_a >> 6) & 32'h3F);
    exp_hit  = look && phase == 0 && m_valid[li] && m_tag[li] == (look_a >> 12);
    exp_data = exp_hit ? memfn(look_a) : 32'd0;
    exp_req  = (phase == 1);
    exp_addr = (phase == 1) ? ((f_tag << 12) | (32'(f_idx) << 6) | (32'(f_cnt) << 2)) : 32'd0;
    model_ready = 1;
  end

  always @(negedge clk) begin
    if (model_ready) begin
      chk("hit",   {31'd0, icache_hit_o},  {31'd0, exp_hit});
      chk("idata", idata_o,                exp_data);
      chk("req",   {31'd0, mem_request_o}, {31'd0, exp_req});
      chk("maddr", mem_address_o,          exp_addr);
    end
  end

  // ---------------- memory responder ----------------
  int ack_mode = 0;   // 0 always, 1 every 4th cycle, 2 random, 3 limited budget
  int gap_cnt = 0;
  int ack_budget = 0;

  always @(negedge clk) begin
    if (mem_request_o === 1'b1) begin
      case (ack_mode)
        0: mem_ack_i = 1'b1;
        1: begin
             mem_ack_i = (gap_cnt == 3);
             gap_cnt   = (gap_cnt == 3) ? 0 : gap_cnt + 1;
           end
        2: mem_ack_i = 1'($urandom_range(0, 1));
        default: begin
             mem_ack_i = (ack_budget > 0);
             if (ack_budget > 0) ack_budget--;
           end
      endcase
      mem_data_i = memfn(mem_address_o);
    end else begin
      mem_ack_i  = ($urandom_range(0, 3) == 0);
      mem_data_i = $urandom;
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit acc, input logic [31:0] a);
    @(negedge clk);
    iaccess_i  = acc;
    iaddress_i = a;
  endtask

  task automatic look_check(input string nm, input logic [31:0] a, input bit eh,
                            input logic [31:0] ed);
    drive(1'b1, a);
    @(negedge clk);
    iaccess_i = 1'b0;
    chk({nm, "_hit"},  {31'd0, icache_hit_o}, {31'd0, eh});
    chk({nm, "_data"}, idata_o, ed);
  endtask

  task automatic wait_fill(input string nm);
    bit seen = 0;
    bit done = 0;
    for (int i = 0; i < 3000 && !done; i++) begin
      if (mem_request_o === 1'b1) seen = 1;
      if (seen && mem_request_o === 1'b0) done = 1;
      else begin
        @(negedge clk);
        iaccess_i = 1'b0;
      end
    end
    n_vec++;
    if (!done) begin
      n_bad++;
      $display("FAIL %s_fill_done: fill did not complete, got seen=%0d expected completion", nm, seen);
    end
    @(negedge clk);
  endtask

  logic [31:0] tag_pool [4];

  initial begin
    tag_pool[0] = 32'h1; tag_pool[1] = 32'h2; tag_pool[2] = 32'h3; tag_pool[3] = 32'h5;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_hit",  {31'd0, icache_hit_o},  32'd0);
    chk("rst_req",  {31'd0, mem_request_o}, 32'd0);
    chk("rst_addr", mem_address_o, 32'd0);
    chk("rst_data", idata_o, 32'd0);

    // Cold miss and fill of line 0x1000
    look_check("cold", 32'h0000_1000, 1'b0, 32'd0);
    drive(1'b0, 32'd0);
    chk("cold_req",   {31'd0, mem_request_o}, 32'd1);
    chk("cold_addr0", mem_address_o, 32'h0000_1000);
    wait_fill("cold");
    look_check("cold_rehit", 32'h0000_1008, 1'b1, 32'hA000_0002);

    // Back-to-back hits
    drive(1'b1, 32'h0000_1000);
    drive(1'b1, 32'h0000_1004);
    look_check("b2b_last", 32'h0000_103C, 1'b1, 32'hA000_000F);

    // Conflict eviction: 0x2000 shares index 0 with 0x1000
    look_check("conf_miss", 32'h0000_2000, 1'b0, 32'd0);
    drive(1'b1, 32'h0000_1000);
    drive(1'b1, 32'h0000_1000);
    drive(1'b0, 32'd0);
    chk("conf_during", {31'd0, icache_hit_o}, 32'd0);
    wait_fill("conf");
    look_check("conf_new", 32'h0000_2000, 1'b1, 32'hA000_0400);
    look_check("conf_old", 32'h0000_1000, 1'b0, 32'd0);
    drive(1'b1, 32'h0000_5000);
    drive(1'b0, 32'd0);
    chk("other_miss", {31'd0, icache_hit_o}, 32'd0);
    chk("same_line", mem_address_o & ~32'h3F, 32'h0000_1000);
    wait_fill("refill");

    // Ack throttling with 3-cycle gaps
    ack_mode = 1; gap_cnt = 0;
    look_check("thr_miss", 32'h0000_3040, 1'b0, 32'd0);
    wait_fill("thr");
    ack_mode = 0;
    for (int w = 0; w < 16; w++)
      look_check("thr_word", 32'h0000_3040 + 32'(w) * 4, 1'b1, memfn(32'h0000_3040 + 32'(w) * 4));

    // Reset in the middle of a fill after 5 acks
    look_check("ev_miss", 32'h0000_2000, 1'b0, 32'd0);
    wait_fill("ev");
    ack_mode = 3; ack_budget = 5;
    look_check("mid_miss", 32'h0000_1000, 1'b0, 32'd0);
    repeat (12) drive(1'b0, 32'd0);
    chk("mid_stall_req",  {31'd0, mem_request_o}, 32'd1);
    chk("mid_stall_addr", mem_address_o, 32'h0000_1014);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    ack_mode = 0;
    chk("mid_rst_req",  {31'd0, mem_request_o}, 32'd0);
    chk("mid_rst_addr", mem_address_o, 32'd0);
    look_check("post_rst", 32'h0000_1000, 1'b0, 32'd0);
    drive(1'b0, 32'd0);
    chk("post_rst_addr0", mem_address_o, 32'h0000_1000);
    wait_fill("post_rst");
    look_check("post_rst_hit", 32'h0000_1010, 1'b1, 32'hA000_0004);

    // Random traffic, random ack timing, rare resets
    ack_mode = 2;
    for (int n = 0; n < 700; n++) begin
      @(negedge clk);
      reset      = ($urandom_range(0, 249) == 0);
      iaccess_i  = ($urandom_range(0, 9) < 7);
      iaddress_i = (tag_pool[$urandom_range(0, 3)] << 12) | (32'($urandom_range(0, 2)) << 6)
                 | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
    end
    reset = 1'b0;
    repeat (3) drive(1'b0, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
